shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use the parameter WIDTH, default 16, meaning the data word width. Only 16 is verified.
REQ-002 The block SHALL use the parameter AMT_W, default 4, meaning the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand, captured on the accepting edge.
REQ-007 The block SHALL have port amt, input, AMT_W bits: shift amount 0..15, captured on the accepting edge.
REQ-008 The block SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROL; captured on the accepting edge.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in the DONE state.
REQ-011 The block SHALL have port r, output, WIDTH bits: result register, held until the next DONE.
REQ-012 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at an edge SHALL load a, op and amt (cnt=amt) into internal registers. The next state SHALL be DONE if amt==0, else RUN.
REQ-015 In IDLE, start=0 SHALL hold all state.
REQ-016 In RUN, each edge SHALL apply one step. If cnt>=4: shift by 4 and cnt-=4. Else: shift by 1 and cnt-=1.
REQ-017 In RUN, when the updated cnt==0, the next state SHALL be DONE.
REQ-018 On entry to DONE, r SHALL take the final working value. DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 Latency SHALL be N = 1 + floor(amt/4) + (amt mod 4) edges from the accepting edge (inclusive) to done=1. Range: N=1 (amt=0) to N=7 (amt=15).
REQ-020 start SHALL be ignored while busy=1, including in DONE. A held start is re-accepted at the first edge in IDLE.
REQ-021 SLL and SRL SHALL fill vacated bits with zero.
REQ-022 SRA SHALL fill vacated bits with the captured a[WIDTH-1].
REQ-023 ROL SHALL wrap the high bits into the low positions.
REQ-024 A 4-bit SLL step SHALL equal {w[11:0],4'h0}. A 4-bit SRL step SHALL equal {4'h0,w[15:4]}.
REQ-025 Input changes on a, amt and op after acceptance SHALL have no effect on the operation in flight.
REQ-026 r SHALL change only on entry to DONE, or on reset.
REQ-027 done SHALL never be high for two consecutive cycles.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, r=0, done=0, busy=0, cnt=0 and working value 0.
REQ-029 Reset SHALL take priority over start and over any in-flight operation. No done pulse SHALL follow an aborted operation.
REQ-030 The first start SHALL be accepted at the first edge with reset=0.

Structure
REQ-031 The package shift_pkg SHALL hold: the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL), the FSM state encoding, and the WIDTH/AMT_W defaults.
REQ-032 One combinational sub-module, shift_step, SHALL be used. Inputs: w[15:0], op, by4. Output: the one-step result.
REQ-033 The shift_sequencer top SHALL hold only the FSM, cnt, the working register and r.

Verification
REQ-034 Scenario 1: SLL, a=0x1234, amt=4 -> r=0x2340; done at edge 2; busy high for 2 cycles.
REQ-035 Scenario 2: SLL, a=0x1234, amt=12 -> r=0x4000, N=4. Then ROL, a=0x1234, amt=7 -> r=0x1A09, N=5.
REQ-036 Scenario 3: SRA, a=0x8001, amt=15 -> r=0xFFFF, N=7. Then SRL, a=0x8001, amt=15 -> r=0x0001.
REQ-037 Scenario 4: SRL, a=0xBEEF, amt=0 -> r=0xBEEF, done at edge 1. Also: a second start pulsed during RUN (a=0x0F0F) is ignored, and r does not show 0x0F0F.
REQ-038 Scenario 5: SLL, amt=15, with reset asserted at the 3rd edge -> r=0x0000, busy=0, and no done pulse in the following 10 cycles.
REQ-039 Scenario 6: start held high for 20 cycles with a=0x0001, SLL, amt=1 -> consecutive results of 0x0002, with done pulses every 3 cycles (accept, DONE, IDLE) and never two in a row.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the shift sequencer.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned AMT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: by 4 when by4 is set, otherwise by 1.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       op,
  input  logic             by4,
  output logic [WIDTH-1:0] res
);

  // Select shift kind and distance; SRA replicates the working MSB, which
  // still equals the captured operand's sign bit.
  always_comb begin
    res = w;
    unique case (op)
      OP_SLL: res = by4 ? {w[WIDTH-5:0], 4'h0} : {w[WIDTH-2:0], 1'b0};
      OP_SRL: res = by4 ? {4'h0, w[WIDTH-1:4]} : {1'b0, w[WIDTH-1:1]};
      OP_SRA: res = by4 ? {{4{w[WIDTH-1]}}, w[WIDTH-1:4]} : {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROL: res = by4 ? {w[WIDTH-5:0], w[WIDTH-1:WIDTH-4]} : {w[WIDTH-2:0], w[WIDTH-1]};
      default: res = w;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts an operation in IDLE, steps by 4 or 1 per
// cycle in RUN, and publishes the result on entry to DONE.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic             by4;
  logic [WIDTH-1:0] step_w;

  assign by4 = (cnt_q >= AMT_W'(4));

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w   (w_q),
    .op  (op_q),
    .by4 (by4),
    .res (step_w)
  );

  // Next-state logic: capture on accept, step while counting down, publish on DONE entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    op_d    = op_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d   = a;
          op_d  = op;
          cnt_d = amt;
          if (amt == '0) begin
            state_d = StDone;
            r_d     = a;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        w_d   = step_w;
        cnt_d = by4 ? (cnt_q - AMT_W'(4)) : (cnt_q - AMT_W'(1));
        if (cnt_d == '0) begin
          state_d = StDone;
          r_d     = step_w;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      w_q     <= '0;
      op_q    <= OP_SLL;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      op_q    <= op_d;
      r_q     <= r_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign r    = r_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: transaction-level latency/result model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [3:0]  amt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] r;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(
    .WIDTH (16),
    .AMT_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .amt   (amt),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-operation result from the shift definitions.
  function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] x,
                                            input int s);
    logic [15:0] y;
    case (o)
      2'b00:   y = x << s;
      2'b01:   y = x >> s;
      2'b10:   y = 16'($signed(x) >>> s);
      default: y = (s == 0) ? x : ((x << s) | (x >> (16 - s)));
    endcase
    return y;
  endfunction

  function automatic int latency(input int s);
    return 1 + s / 4 + s % 4;
  endfunction

  // Behavioural model: an accepted op completes after a fixed edge count.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_r    = 16'h0;
  logic [15:0] m_res  = 16'h0;
  int          m_rem  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_r    = 16'h0;
      m_rem  = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_res  = ref_shift(op, a, int'(amt));
        m_rem  = latency(int'(amt)) - 1;
        m_busy = 1'b1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_r    = m_res;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_r    = m_res;
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("r", 32'(r), 32'(m_r));
  end

  // Caller is at a negedge with the DUT idle; returns with the DUT idle again.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] av,
                        input logic [3:0] am, input logic [15:0] er, input int en);
    int n;
    logic seen;
    start = 1'b1;
    a     = av;
    op    = o;
    amt   = am;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    amt   = 4'($urandom);
    op    = 2'($urandom);
    n     = 1;
    seen  = done;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = done;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(en));
    chk({nm, "_r"}, 32'(r), 32'(er));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    logic seen;
    reset = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    amt   = 4'h0;
    op    = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    reset = 1'b0;

    // First start lands on the first edge with reset low.
    run_op("s1_sll4", 2'b00, 16'h1234, 4'd4, 16'h2340, 2);
    @(negedge clk); run_op("s2_sll12", 2'b00, 16'h1234, 4'd12, 16'h4000, 4);
    @(negedge clk); run_op("s2_rol7", 2'b11, 16'h1234, 4'd7, 16'h1A09, 5);
    @(negedge clk); run_op("s3_sra15", 2'b10, 16'h8001, 4'd15, 16'hFFFF, 7);
    @(negedge clk); run_op("s3_srl15", 2'b01, 16'h8001, 4'd15, 16'h0001, 7);
    @(negedge clk); run_op("s4_srl0", 2'b01, 16'hBEEF, 4'd0, 16'hBEEF, 1);

    // A start pulsed during RUN is ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h00FF; op = 2'b00; amt = 4'd15;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F; op = 2'b00; amt = 4'd0;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    seen = done;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++; seen = done;
    end
    chk("s4_ignored_done_seen", 32'(seen), 32'd1);
    chk("s4_ignored_r", 32'(r), 32'h8000);
    @(posedge clk); #1;
    chk("s4_back_idle", 32'(busy), 32'd0);

    // Reset at the third edge of a long operation.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; op = 2'b00; amt = 4'd15;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("s5_r", 32'(r), 32'h0000);
    chk("s5_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("s5_no_done", 32'(pulses), 32'd0);

    // Held start: back-to-back operations every three edges.
    @(negedge clk);
    start = 1'b1; a = 16'h0001; op = 2'b00; amt = 4'd1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        chk("s6_r", 32'(r), 32'h0002);
        chk("s6_pulse_edge", 32'(i % 3), 32'd2);
      end
    end
    start = 1'b0;
    chk("s6_pulses", 32'(pulses), 32'd7);
    repeat (2) @(posedge clk);

    // Random traffic including starts while busy, input churn and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) != 0);
      a     = 16'($urandom);
      op    = 2'($urandom);
      amt   = 4'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
